zsdram_rr_arbit: RTL



---
 rtl/zsdram_rr_arbit_if.sv | 43 ++++
 rtl/zsdram_rr_arbit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/zsdram_rr_arbit_if.sv
// Requester / controller bundle of the round-robin SDRAM arbiter.
//   slave  : arbiter view (requests and controller responses in; grants,
//            completions and controller commands out).
//   master : environment view (requesters plus SDRAM controller).
// Port p's address sits at iAddr[p*AW +: AW]; its write burst word w sits at
// iWData[(p*BURST+w)*DW +: DW].
`timescale 1ns/1ps
interface zsdram_rr_arbit_if #(
  parameter int unsigned NPORT = 4,
  parameter int unsigned AW    = 24,
  parameter int unsigned DW    = 16,
  parameter int unsigned BURST = 4
);
  localparam int unsigned GW = $clog2(NPORT);
  localparam int unsigned BW = BURST * DW;

  logic                      en;
  logic                      iExclusive;
  logic [NPORT-1:0]          iReq;
  logic [NPORT-1:0]          iWr;
  logic [NPORT*AW-1:0]       iAddr;
  logic [NPORT*BW-1:0]       iWData;
  logic [NPORT-1:0]          oDone;
  logic                      oErr;
  logic [BW-1:0]             oRData;
  logic [GW-1:0]             oGrant;
  logic                      oBusy;
  logic [1:0]                oMemReq;
  logic [AW-1:0]             oMemAddr;
  logic [BW-1:0]             oMemWData;
  logic [BW-1:0]             iMemRData;
  logic [1:0]                iMemDone;

  modport slave (
    input  en, iExclusive, iReq, iWr, iAddr, iWData, iMemRData, iMemDone,
    output oDone, oErr, oRData, oGrant, oBusy, oMemReq, oMemAddr, oMemWData
  );

  modport master (
    output en, iExclusive, iReq, iWr, iAddr, iWData, iMemRData, iMemDone,
    input  oDone, oErr, oRData, oGrant, oBusy, oMemReq, oMemAddr, oMemWData
  );
endinterface

// File: rtl/zsdram_rr_arbit.sv
// Round-robin arbiter between NPORT burst requesters and a single four-word
// burst SDRAM controller, with a port-0-only exclusive mode and a watchdog
// that aborts transfers the controller never completes.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : zsdram_rr_arbit_if.slave (requester handshake, shared read
//                burst, grant/busy status and controller command/response)
`timescale 1ns/1ps
module zsdram_rr_arbit #(
  parameter int unsigned NPORT   = 4,
  parameter int unsigned AW      = 24,
  parameter int unsigned DW      = 16,
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  zsdram_rr_arbit_if.slave  bus
);

  localparam int unsigned GW  = $clog2(NPORT);
  localparam int unsigned BW  = BURST * DW;
  localparam int unsigned WDW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit          WD_EN = (TIMEOUT != 0);
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     ptr_q, ptr_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic              wr_q, wr_d;
  logic [1:0]        mem_req_q, mem_req_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [BW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]     rdata_q, rdata_d;
  logic [NPORT-1:0]  done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [WDW-1:0]    wdog_q, wdog_d;

  logic [NPORT-1:0]  elig;
  logic              pick_vld;
  logic [GW-1:0]     pick_idx;
  logic              pick_wr;
  logic [AW-1:0]     pick_addr;
  logic [BW-1:0]     pick_wdata;
  int unsigned       cand;
  logic              mem_hit;
  logic              wd_expire;

  // Round-robin pick: first eligible port at or after ptr, wrapping upward.
  always_comb begin
    elig     = bus.iExclusive ? (bus.iReq & NPORT'(1)) : bus.iReq;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = 0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      cand = (32'(ptr_q) + i) % NPORT;
      if (!pick_vld && elig[cand]) begin
        pick_vld = 1'b1;
        pick_idx = GW'(cand);
      end
    end
    pick_wr    = bus.iWr[pick_idx];
    pick_addr  = bus.iAddr[32'(pick_idx) * AW +: AW];
    pick_wdata = bus.iWData[32'(pick_idx) * BW +: BW];
  end

  // Only the done bit matching the latched direction completes a transfer.
  assign mem_hit   = wr_q ? bus.iMemDone[1] : bus.iMemDone[0];
  assign wd_expire = WD_EN && (wdog_q == WD_LAST) && !mem_hit;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; dropping en forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (pick_vld) state_d = S_BUSY;
      S_BUSY:  if (mem_hit || wd_expire) state_d = S_DONE;
      S_DONE:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (!bus.en) state_d = S_IDLE;
  end

  // Output / datapath next values.
  always_comb begin
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    wr_d        = wr_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    done_d      = done_q;
    err_d       = err_q;
    wdog_d      = wdog_q;
    busy_d      = (state_d != S_IDLE);

    if (!bus.en) begin
      // Abort silently: pointer and last read burst are kept.
      mem_req_d = 2'b00;
      done_d    = '0;
      err_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_d     = pick_idx;
            wr_d        = pick_wr;
            mem_addr_d  = pick_addr;
            mem_wdata_d = pick_wdata;
            mem_req_d   = {pick_wr, ~pick_wr};
            wdog_d      = '0;
          end
        end
        S_BUSY: begin
          wdog_d = wdog_q + WDW'(1);
          if (mem_hit) begin
            mem_req_d = 2'b00;
            if (!wr_q) rdata_d = bus.iMemRData;
            done_d = NPORT'(1) << grant_q;
          end else if (wd_expire) begin
            mem_req_d = 2'b00;
            done_d    = NPORT'(1) << grant_q;
            err_d     = 1'b1;
          end
        end
        S_DONE: begin
          done_d = '0;
          err_d  = 1'b0;
          ptr_d  = (32'(grant_q) == NPORT - 1) ? '0 : grant_q + GW'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      grant_q     <= '0;
      wr_q        <= 1'b0;
      mem_req_q   <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      wdog_q      <= '0;
    end else begin
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      wr_q        <= wr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      wdog_q      <= wdog_d;
    end
  end

  assign bus.oDone     = done_q;
  assign bus.oErr      = err_q;
  assign bus.oRData    = rdata_q;
  assign bus.oGrant    = grant_q;
  assign bus.oBusy     = busy_q;
  assign bus.oMemReq   = mem_req_q;
  assign bus.oMemAddr  = mem_addr_q;
  assign bus.oMemWData = mem_wdata_q;

  // Completion is always a single port.
  a_done_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(done_q));

endmodule
